// File: rtl/hello_world_qsys_nios_cpu_div_pkg.sv
// ---------------------------------------------------------------------------
// hello_world_qsys_nios_cpu_div_pkg
// Shared definitions for the iterative Nios CPU divider:
//   - DIV_WIDTH : default operand/result width
//   - DIV_CNT_W : step-counter width for the default width
//   - div_state_t : divider FSM states
// ---------------------------------------------------------------------------
package hello_world_qsys_nios_cpu_div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/hello_world_qsys_nios_cpu_div_step.sv
// ---------------------------------------------------------------------------
// hello_world_qsys_nios_cpu_div_step
// One combinational radix-2 restoring division step.
//   rq_in   : {partial remainder, quotient/dividend shift register}
//   divisor : divisor magnitude
//   rq_out  : {rem,quot} after shifting left by one and conditionally
//             subtracting the divisor (quotient LSB = 1 when subtracted)
// ---------------------------------------------------------------------------
module hello_world_qsys_nios_cpu_div_step
  import hello_world_qsys_nios_cpu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [2*WIDTH-1:0] rq_in,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] rq_out
);

  // The shifted remainder needs one extra bit: the remainder can be as large
  // as divisor-1, which after doubling may exceed WIDTH bits.
  logic [WIDTH:0] partial;
  logic [WIDTH:0] diff;

  always_comb begin
    partial = {rq_in[2*WIDTH-1:WIDTH], rq_in[WIDTH-1]};
    diff    = partial - {1'b0, divisor};
    // A clear borrow bit means partial >= divisor.
    if (!diff[WIDTH]) begin
      rq_out = {diff[WIDTH-1:0], rq_in[WIDTH-2:0], 1'b1};
    end else begin
      rq_out = {partial[WIDTH-1:0], rq_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/hello_world_qsys_nios_cpu_div_cell.sv
// ---------------------------------------------------------------------------
// hello_world_qsys_nios_cpu_div_cell
// Iterative signed/unsigned integer divider (radix-2 restoring).
//   clk, reset    : clock, synchronous active-high reset
//   E_src1/E_src2 : dividend / divisor, sampled on an accepted start
//   E_div_start   : request, accepted only in IDLE (M_div_busy = 0)
//   E_div_signed  : 1 = two's-complement operands
//   M_div_quot    : quotient, valid from done until the next result
//   M_div_rem     : remainder, same validity
//   M_div_done    : one-cycle result-valid pulse
//   M_div_busy    : high from the cycle after accept through the done cycle
// Latency: done in cycle WIDTH+2 after the accept cycle.
// Divide by zero returns quot = all ones, rem = dividend.
// Optional macro NIOS_DIV_ZERO_SHORTCUT_EN: a zero divisor skips RUN and
// completes in cycle 2 with identical results.
// ---------------------------------------------------------------------------
module hello_world_qsys_nios_cpu_div_cell
  import hello_world_qsys_nios_cpu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] E_src1,
  input  logic [WIDTH-1:0] E_src2,
  input  logic             E_div_start,
  input  logic             E_div_signed,
  output logic [WIDTH-1:0] M_div_quot,
  output logic [WIDTH-1:0] M_div_rem,
  output logic             M_div_done,
  output logic             M_div_busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  div_state_t state_q, state_d;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] raw_src1_q, raw_src1_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] res_quot_q, res_quot_d;
  logic [WIDTH-1:0] res_rem_q, res_rem_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             accept;
  logic             src1_neg, src2_neg, src2_zero;
  logic [2*WIDTH-1:0] step_out;

  assign accept    = (state_q == IDLE) && E_div_start;
  assign src1_neg  = E_div_signed && E_src1[WIDTH-1];
  assign src2_neg  = E_div_signed && E_src2[WIDTH-1];
  assign src2_zero = (E_src2 == '0);

  hello_world_qsys_nios_cpu_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rq_in   ({rem_q, quot_q}),
    .divisor (dvsr_q),
    .rq_out  (step_out)
  );

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (E_div_start) begin
`ifdef NIOS_DIV_ZERO_SHORTCUT_EN
          state_d = src2_zero ? FIX : RUN;
`else
          state_d = RUN;
`endif
        end
      end
      RUN:     if (cnt_q == LAST_STEP) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves it unassigned, which would infer a latch.
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    dvsr_d     = dvsr_q;
    raw_src1_d = raw_src1_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    res_quot_d = res_quot_q;
    res_rem_d  = res_rem_q;
    done_d     = 1'b0;
    busy_d     = busy_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          // Work on magnitudes; the most-negative value maps onto itself,
          // which is its correct unsigned magnitude.
          quot_d     = src1_neg ? -E_src1 : E_src1;
          dvsr_d     = src2_neg ? -E_src2 : E_src2;
          rem_d      = '0;
          cnt_d      = '0;
          raw_src1_d = E_src1;
          neg_quot_d = src1_neg ^ src2_neg;
          neg_rem_d  = src1_neg;
          div_zero_d = src2_zero;
          busy_d     = 1'b1;
        end
      end
      RUN: begin
        {rem_d, quot_d} = step_out;
        cnt_d           = cnt_q + 1'b1;
      end
      FIX: begin
        if (div_zero_q) begin
          res_quot_d = '1;
          res_rem_d  = raw_src1_q;
        end else begin
          res_quot_d = neg_quot_q ? -quot_q : quot_q;
          res_rem_d  = neg_rem_q  ? -rem_q  : rem_q;
        end
        done_d = 1'b1;
      end
      DONE: begin
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      dvsr_q     <= '0;
      raw_src1_q <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      res_quot_q <= '0;
      res_rem_q  <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      dvsr_q     <= dvsr_d;
      raw_src1_q <= raw_src1_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      res_quot_q <= res_quot_d;
      res_rem_q  <= res_rem_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign M_div_quot = res_quot_q;
  assign M_div_rem  = res_rem_q;
  assign M_div_done = done_q;
  assign M_div_busy = busy_q;

endmodule

// File: tb/tb_hello_world_qsys_nios_cpu_div_cell.sv
// ---------------------------------------------------------------------------
// tb_hello_world_qsys_nios_cpu_div_cell
// Directed self-checking bench for the iterative divider (WIDTH = 32).
// Cycle 0 is the cycle in which start is presented and accepted.
// ---------------------------------------------------------------------------
module tb_hello_world_qsys_nios_cpu_div_cell;

`ifdef NIOS_DIV_ZERO_SHORTCUT_EN
  localparam int ZERO_LAT = 2;
`else
  localparam int ZERO_LAT = 34;
`endif
  localparam int FULL_LAT = 34;

  logic        clk;
  logic        reset;
  logic [31:0] E_src1;
  logic [31:0] E_src2;
  logic        E_div_start;
  logic        E_div_signed;
  logic [31:0] M_div_quot;
  logic [31:0] M_div_rem;
  logic        M_div_done;
  logic        M_div_busy;

  int checks;
  int failures;
  int cyc;

  hello_world_qsys_nios_cpu_div_cell dut (
    .clk          (clk),
    .reset        (reset),
    .E_src1       (E_src1),
    .E_src2       (E_src2),
    .E_div_start  (E_div_start),
    .E_div_signed (E_div_signed),
    .M_div_quot   (M_div_quot),
    .M_div_rem    (M_div_rem),
    .M_div_done   (M_div_done),
    .M_div_busy   (M_div_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sampling and driving happen 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One complete operation: checks latency, busy through done, results,
  // and that busy/done drop the cycle after done.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, input logic [31:0] exp_q, input logic [31:0] exp_r,
                        input int exp_lat);
    bit busy_ok;
    bit seen;
    busy_ok = 1'b1;
    seen    = 1'b0;
    E_src1       = a;
    E_src2       = b;
    E_div_signed = sgn;
    E_div_start  = 1'b1;
    cyc = 0;
    tick();
    E_div_start = 1'b0;
    while (cyc <= 100) begin
      if (!M_div_busy) busy_ok = 1'b0;
      if (M_div_done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_lat"}, seen ? cyc : -1, exp_lat);
    check({tag, "_busy"}, busy_ok, 1'b1);
    check({tag, "_quot"}, M_div_quot, exp_q);
    check({tag, "_rem"}, M_div_rem, exp_r);
    tick();
    check({tag, "_idle"}, {M_div_busy, M_div_done}, 2'b00);
  endtask

  initial begin
    int done_cnt;
    int done1;
    int done2;
    checks       = 0;
    failures     = 0;
    cyc          = 0;
    reset        = 1'b1;
    E_src1       = '0;
    E_src2       = '0;
    E_div_start  = 1'b0;
    E_div_signed = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("reset_state", {M_div_quot, M_div_rem, M_div_busy, M_div_done}, '0);

    run_op("u100_7",  32'd100,        32'd7,          1'b0, 32'd14,         32'd2,         FULL_LAT);
    run_op("s-7_2",   32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF, FULL_LAT);
    run_op("s7_-2",   32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,         FULL_LAT);
    run_op("u_div0",  32'h1234,       32'd0,          1'b0, 32'hFFFF_FFFF,  32'h1234,      ZERO_LAT);
    run_op("s_div0",  32'h1234,       32'd0,          1'b1, 32'hFFFF_FFFF,  32'h1234,      ZERO_LAT);
    run_op("s_ovf",   32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,         FULL_LAT);
    run_op("u_max_1", 32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,         FULL_LAT);

    // Start while busy is ignored; start in cycle 35 (IDLE after DONE) accepted.
    done_cnt     = 0;
    done1        = -1;
    done2        = -1;
    E_src1       = 32'd10;
    E_src2       = 32'd3;
    E_div_signed = 1'b0;
    E_div_start  = 1'b1;
    cyc = 0;
    while (cyc < 75) begin
      tick();
      if (M_div_done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done1 = cyc;
          check("busy_q1", M_div_quot, 32'd3);
          check("busy_r1", M_div_rem, 32'd1);
        end else if (done_cnt == 2) begin
          done2 = cyc;
          check("b2b_q2", M_div_quot, 32'd10);
          check("b2b_r2", M_div_rem, 32'd0);
        end
      end
      E_div_start = 1'b0;
      if (cyc == 5 || cyc == 35) begin
        E_src1      = 32'd50;
        E_src2      = 32'd5;
        E_div_start = 1'b1;
      end
    end
    check("busy_done1_cyc", done1, 34);
    check("b2b_done2_cyc", done2, 69);
    check("busy_done_cnt", done_cnt, 2);

    // Leave non-zero held results, then abort a run with reset in cycle 10.
    run_op("u123_10", 32'd123, 32'd10, 1'b0, 32'd12, 32'd3, FULL_LAT);
    E_src1       = 32'd100;
    E_src2       = 32'd7;
    E_div_signed = 1'b0;
    E_div_start  = 1'b1;
    cyc = 0;
    tick();
    E_div_start = 1'b0;
    while (cyc < 10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_abort_state", {M_div_quot, M_div_rem, M_div_busy, M_div_done}, '0);
    done_cnt = 0;
    while (cyc < 50) begin
      tick();
      if (M_div_done) done_cnt++;
    end
    check("rst_no_done", done_cnt, 0);
    run_op("post_rst", 32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, FULL_LAT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hello_world_qsys_nios_cpu_div_cell.md
# hello_world_qsys_nios_cpu_div_cell

Iterative 32-bit integer divider for the Nios CPU execute/memory path; the multi-cycle inverse of the multiply cell. It accepts a dividend/divisor pair from the E stage and runs a radix-2 restoring division. It returns quotient and remainder with a one-cycle done pulse, and the pipeline stalls on busy. It supports signed and unsigned operation, with defined divide-by-zero and overflow results.

## Interface
- WIDTH, 32, operand/result width; must be even and at least 4
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset (one clock; reset is synchronous and active-high)
- E_src1  input  WIDTH  dividend, sampled on accepted start
- E_src2  input  WIDTH  divisor, sampled on accepted start
- E_div_start  input  1  request; accepted only when M_div_busy=0
- E_div_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
- M_div_quot  output  WIDTH  quotient, valid from done, held until next accepted start
- M_div_rem  output  WIDTH  remainder, same validity
- M_div_done  output  1  one-cycle pulse, results valid
- M_div_busy  output  1  high from cycle after accept through done cycle

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE: on E_div_start, latch |src1| and |src2| (magnitudes if signed), dividend sign, quotient sign (src1 sign XOR src2 sign), a zero-divisor flag, and the raw src1. Clear the partial remainder and step counter. Go to RUN.
- RUN: each cycle shifts {rem,quot} left 1. If rem ≥ divisor, subtract and set quot LSB=1. The counter runs 0..WIDTH-1; at WIDTH-1 go to FIX.
- FIX, signed correction:
  - quotient is negated if the quotient sign is set
  - remainder takes the sign of the dividend
- FIX, divide by zero overrides any sign correction:
  - quot = all ones
  - rem = raw src1
- DONE: assert M_div_done for one cycle and go to IDLE. Results stay held.
- Signed overflow (most-negative / -1): quot = 0x80000000, rem = 0; this falls out of the magnitude path.
- E_div_start while busy is ignored; no queueing.
- A start in the DONE cycle is ignored. A start is accepted in the cycle immediately after DONE (IDLE).
- Reset in any state:
  - next cycle is IDLE
  - quot=0, rem=0, done=0, busy=0
  - no done pulse for the aborted operation

## Timing
- Start accepted in cycle 0.
- Busy is high in cycles 1..WIDTH+2.
- RUN occupies cycles 1..WIDTH and FIX occupies cycle WIDTH+1.
- M_div_done is high in cycle WIDTH+2 (34 for WIDTH=32).
- Back-to-back: the next start is accepted in cycle WIDTH+3 at the earliest.
- Outputs are registered; there is no combinational path from inputs to outputs.
- Reset values: all outputs 0.

## Configuration
- NIOS_DIV_ZERO_SHORTCUT_EN defined: a zero divisor skips RUN.
  - IDLE goes directly to FIX.
  - Done in cycle 2 and busy in cycles 1..2.
  - Results are identical to the non-shortcut case.
- Undefined: a zero divisor takes the full WIDTH+2 latency, with results forced in FIX.

## Structure
- Package hello_world_qsys_nios_cpu_div_pkg holds:
  - the state enum (IDLE/RUN/FIX/DONE)
  - the default WIDTH constant
  - the counter width constant, $clog2(WIDTH)
- One sub-module, hello_world_qsys_nios_cpu_div_step: combinational single restoring step.
  - Input: {rem,quot}, divisor.
  - Output: next {rem,quot}.
  - Instantiated once in RUN.

## Test plan
- Unsigned 100 / 7 → quot 14, rem 2; done exactly in cycle 34, busy in cycles 1..34.
- Signed -7 / 2 → quot 0xFFFFFFFD, rem 0xFFFFFFFF. Signed 7 / -2 → quot 0xFFFFFFFD, rem 1.
- 0x1234 / 0, both signed and unsigned → quot 0xFFFFFFFF, rem 0x1234.
  - Latency 34 without the macro, 2 with it.
- Signed 0x80000000 / 0xFFFFFFFF → quot 0x80000000, rem 0. Unsigned 0xFFFFFFFF / 1 → quot 0xFFFFFFFF, rem 0.
- Busy handling:
  - Start with 10/3, then pulse start with 50/5 in cycle 5 → only 3 r 1 is reported, one done pulse.
  - A new start in cycle 35 → 50/5 = 10 r 0, done in cycle 69.
- Reset asserted in cycle 10 of RUN → cycle 11 shows busy=0 and quot=rem=0, with no done pulse. A fresh start then completes normally.
